// File: rtl/udp_tx_sched.sv
// Packet-granular round-robin scheduler merging NUM_SRC streams into one udp_top write stream.
// Optional header word per packet when UDP_TX_SCHED_HDR_EN is defined.
module udp_tx_sched #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 256,
  parameter int IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*DATA_W-1:0] s_data,
  input  logic [NUM_SRC-1:0]        s_valid,
  input  logic [NUM_SRC-1:0]        s_last,
  output logic [NUM_SRC-1:0]        s_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_valid,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy,
  output logic [31:0]               pkt_cnt,
  output logic [15:0]               trunc_cnt
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_XFER
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [31:0]      pkt_cnt_q, pkt_cnt_d;
  logic [15:0]      trunc_cnt_q, trunc_cnt_d;

  logic [DATA_W-1:0] g_data;
  logic              g_valid;
  logic              g_last;
  logic              at_max;
  logic              hs;
  logic              found;
  logic [IDX_W-1:0]  sel;

  assign g_data  = s_data[int'(grant_q)*DATA_W +: DATA_W];
  assign g_valid = s_valid[grant_q];
  assign g_last  = s_last[grant_q];
  assign at_max  = (word_cnt_q == LAST_CNT);
  assign hs      = g_valid && m_ready;

  // Search starts just above the last grant so the previous winner has lowest priority.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(grant_q) + k) % NUM_SRC;
      if (!found && s_valid[idx]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
  end

`ifdef UDP_TX_SCHED_HDR_EN
  logic [15:0]       seq_q, seq_d;
  logic [DATA_W-1:0] hdr_word;

  always_comb begin
    hdr_word                 = '0;
    hdr_word[DATA_W-1 -: 8]  = 8'(grant_q);
    hdr_word[15:0]           = seq_q;
  end
`endif

  // NOTE: every output and next-state value gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    word_cnt_d  = word_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
`ifdef UDP_TX_SCHED_HDR_EN
    seq_d       = seq_q;
`endif
    s_ready     = '0;
    m_data      = '0;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    busy        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d    = sel;
          word_cnt_d = '0;
`ifdef UDP_TX_SCHED_HDR_EN
          state_d    = ST_HDR;
`else
          state_d    = ST_XFER;
`endif
        end
      end

`ifdef UDP_TX_SCHED_HDR_EN
      ST_HDR: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_data  = hdr_word;
        if (m_ready) begin
          seq_d   = seq_q + 16'd1;
          state_d = ST_XFER;
        end
      end
`endif

      ST_XFER: begin
        busy             = 1'b1;
        m_data           = g_data;
        m_valid          = g_valid;
        m_last           = g_last || at_max;
        s_ready[grant_q] = m_ready;
        if (hs) begin
          if (g_last || at_max) begin
            // Forced last leaves the source's remaining words to compete as a fresh packet.
            word_cnt_d = '0;
            pkt_cnt_d  = pkt_cnt_q + 32'd1;
            if (!g_last && trunc_cnt_q != 16'hFFFF) trunc_cnt_d = trunc_cnt_q + 16'd1;
            state_d    = ST_IDLE;
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= IDX_W'(NUM_SRC - 1);
      word_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      trunc_cnt_q <= '0;
`ifdef UDP_TX_SCHED_HDR_EN
      seq_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      word_cnt_q  <= word_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
`ifdef UDP_TX_SCHED_HDR_EN
      seq_q       <= seq_d;
`endif
    end
  end

  assign grant_idx = grant_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign trunc_cnt = trunc_cnt_q;

endmodule

// File: tb/tb_udp_tx_sched.sv
// Scoreboard bench for udp_tx_sched (NUM_SRC=4, MAX_WORDS=8); expected words are queued as
// stimulus is issued and compared as the DUT hands them off. Define UDP_TX_SCHED_HDR_EN for header mode.
module tb_udp_tx_sched;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int MW = 8;

  typedef struct packed {
    logic [1:0]  src;
    logic        last;
    logic [31:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [NS*DW-1:0] s_data;
  logic [NS-1:0]  s_valid;
  logic [NS-1:0]  s_last;
  logic [NS-1:0]  s_ready;
  logic [DW-1:0]  m_data;
  logic           m_valid;
  logic           m_last;
  logic           m_ready;
  logic [1:0]     grant_idx;
  logic           busy;
  logic [31:0]    pkt_cnt;
  logic [15:0]    trunc_cnt;

  udp_tx_sched #(.NUM_SRC(NS), .DATA_W(DW), .MAX_WORDS(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .grant_idx (grant_idx),
    .busy      (busy),
    .pkt_cnt   (pkt_cnt),
    .trunc_cnt (trunc_cnt)
  );

  always #4 clk = ~clk;

  exp_t        sb[$];
  logic [32:0] src_q[NS][$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  int          hs_cnt = 0;
  bit          prev_last = 0;
  bit          chk_gap = 0;
  logic        mr_next = 1'b1;
  logic        rst_next = 1'b1;
  logic [NS-1:0] acc = '0;
  logic [15:0] exp_seq = '0;

  // One clock: apply inputs just after the rising edge, sample outputs on the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      s_valid[i] = (src_q[i].size() != 0);
      s_data[i*DW +: DW] = (src_q[i].size() != 0) ? src_q[i][0][31:0] : '0;
      s_last[i] = (src_q[i].size() != 0) ? src_q[i][0][32] : 1'b0;
    end
    m_ready = mr_next;
    rst     = rst_next;
    @(negedge clk);
    cyc++;
    acc = s_valid & s_ready;
    if (rst) prev_last = 0;
    if (!rst && m_valid && m_ready) begin
      hs_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word got data=%h last=%b src=%0d", m_data, m_last, grant_idx);
      end else begin
        e = sb.pop_front();
        if (m_data !== e.data || m_last !== e.last || grant_idx !== e.src) begin
          failures++;
          $display("FAIL out_word got data=%h last=%b src=%0d expected data=%h last=%b src=%0d",
                   m_data, m_last, grant_idx, e.data, e.last, e.src);
        end
      end
      if (chk_gap && prev_last) begin
        checks++;
        if (cyc - last_cyc != 2) begin
          failures++;
          $display("FAIL packet_gap got=%0d cycles expected=2", cyc - last_cyc);
        end
      end
      prev_last = m_last;
      last_cyc  = cyc;
    end
  endtask

  task automatic push_packet(input int src, input int n, input logic [31:0] base);
    exp_t e;
    for (int k = 0; k < n; k++) begin
`ifdef UDP_TX_SCHED_HDR_EN
      if (k % MW == 0) begin
        e.src  = 2'(src);
        e.last = 1'b0;
        e.data = {8'(src), 8'h00, exp_seq};
        sb.push_back(e);
        exp_seq++;
      end
`endif
      src_q[src].push_back({(k == n - 1), 32'(base + k)});
      e.src  = 2'(src);
      e.last = (k == n - 1) || (k % MW == MW - 1);
      e.data = 32'(base + k);
      sb.push_back(e);
    end
  endtask

  task automatic flush();
    sb.delete();
    for (int i = 0; i < NS; i++) src_q[i].delete();
    exp_seq = '0;
    acc     = '0;
  endtask

  task automatic do_reset();
    rst_next = 1'b1;
    mr_next  = 1'b1;
    flush();
    tick();
    tick();
    rst_next = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input string name);
    int n;
    bit pending;
    n = 0;
    pending = 1;
    while (pending && n < 300) begin
      tick();
      n++;
      pending = busy || (sb.size() != 0);
      for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) pending = 1;
    end
    checks++;
    if (pending) begin
      failures++;
      $display("FAIL %s_drain_timeout left=%0d words busy=%b", name, sb.size(), busy);
      flush();
    end
  endtask

  task automatic test_reset();
    rst_next = 1'b1;
    flush();
    tick();
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0 || busy !== 1'b0 || s_ready !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b last=%b data=%h busy=%b s_ready=%b expected all zero",
               m_valid, m_last, m_data, busy, s_ready);
    end
    checks++;
    if (grant_idx !== 2'd3 || pkt_cnt !== 32'd0 || trunc_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state got grant=%0d pkt=%0d trunc=%0d expected grant=3 pkt=0 trunc=0",
               grant_idx, pkt_cnt, trunc_cnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    push_packet(1, 3, 32'hA0);
    wait_drain("single");
    checks++;
    if (grant_idx !== 2'd1 || pkt_cnt !== 32'd1 || busy !== 1'b0 || trunc_cnt !== 16'd0) begin
      failures++;
      $display("FAIL single_state got grant=%0d pkt=%0d busy=%b trunc=%0d expected 1 1 0 0",
               grant_idx, pkt_cnt, busy, trunc_cnt);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    push_packet(0, 2, 32'h10);
    push_packet(1, 2, 32'h20);
    push_packet(2, 2, 32'h30);
    push_packet(3, 2, 32'h40);
    push_packet(0, 2, 32'h18);
    chk_gap = 1;
    wait_drain("round_robin");
    chk_gap = 0;
    checks++;
    if (pkt_cnt !== 32'd5 || trunc_cnt !== 16'd0 || grant_idx !== 2'd0) begin
      failures++;
      $display("FAIL rr_state got pkt=%0d trunc=%0d grant=%0d expected 5 0 0", pkt_cnt, trunc_cnt, grant_idx);
    end
  endtask

  task automatic test_truncation();
    do_reset();
    push_packet(2, 11, 32'hC0);
    wait_drain("truncation");
    checks++;
    if (pkt_cnt !== 32'd2 || trunc_cnt !== 16'd1) begin
      failures++;
      $display("FAIL trunc_counts got pkt=%0d trunc=%0d expected pkt=2 trunc=1", pkt_cnt, trunc_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    push_packet(3, 4, 32'hD0);
    for (int c = 0; c < 16; c++) begin
      mr_next = (c % 2 == 0);
      tick();
      if (busy) begin
        checks++;
`ifdef UDP_TX_SCHED_HDR_EN
        if ((s_ready & 4'b0111) !== 4'b0000) begin
          failures++;
          $display("FAIL bp_sready got=%b expected low bits 000", s_ready);
        end
`else
        if (s_ready !== {m_ready, 3'b000}) begin
          failures++;
          $display("FAIL bp_sready got=%b expected=%b", s_ready, {m_ready, 3'b000});
        end
`endif
      end
    end
    mr_next = 1'b1;
    wait_drain("backpressure");
    checks++;
    if (pkt_cnt !== 32'd1) begin
      failures++;
      $display("FAIL bp_pkt_cnt got=%0d expected=1", pkt_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    push_packet(0, 5, 32'hE0);
    hs_cnt = 0;
    n = 0;
    while (hs_cnt < 2 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (hs_cnt < 2) begin
      failures++;
      $display("FAIL mid_reset_timeout got=%0d words expected=2", hs_cnt);
    end
    rst_next = 1'b1;
    tick();
    flush();
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || pkt_cnt !== 32'd0 || trunc_cnt !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs got valid=%b last=%b busy=%b pkt=%0d trunc=%0d expected zeros",
               m_valid, m_last, busy, pkt_cnt, trunc_cnt);
    end
    tick();
    rst_next = 1'b0;
    push_packet(0, 2, 32'hF0);
    push_packet(1, 2, 32'hF8);
    wait_drain("post_reset");
    checks++;
    if (pkt_cnt !== 32'd2 || grant_idx !== 2'd1) begin
      failures++;
      $display("FAIL post_reset_state got pkt=%0d grant=%0d expected pkt=2 grant=1", pkt_cnt, grant_idx);
    end
  endtask

`ifdef UDP_TX_SCHED_HDR_EN
  task automatic test_hdr();
    do_reset();
    push_packet(1, 2, 32'h100);
    wait_drain("hdr_a");
    push_packet(1, 2, 32'h110);
    wait_drain("hdr_b");
    push_packet(2, 2, 32'h120);
    wait_drain("hdr_c");
    checks++;
    if (pkt_cnt !== 32'd3 || exp_seq !== 16'd3) begin
      failures++;
      $display("FAIL hdr_counts got pkt=%0d seq=%0d expected 3 3", pkt_cnt, exp_seq);
    end
  endtask
`endif

  initial begin
    rst     = 1'b1;
    m_ready = 1'b1;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_truncation();
    test_backpressure();
    test_reset_mid();
`ifdef UDP_TX_SCHED_HDR_EN
    test_hdr();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
